// File: rtl/conv_stream_ctrl.sv
// Per-layer sequencer for the 3x3 line-buffer stage: streams activations, appends flush zeros, tags windows.
// Latency 1 from feed issue to lb_in_valid/conv_valid; windowed feeds stall on look-ahead conv_ready.
module conv_stream_ctrl #(
    parameter int IMG_H  = 28,
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          cfg_base,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       lb_rst,
    output logic                       lb_in_valid,
    output logic                       lb_zero,
    input  logic                       conv_ready,
    output logic                       conv_valid,
    output logic [$clog2(IMG_W)-1:0]   out_x,
    output logic [$clog2(IMG_H)-1:0]   out_y
);

    localparam int NPIX  = IMG_H * IMG_W;
    localparam int NFEED = NPIX + IMG_W + 1;
    localparam int KW    = $clog2(NPIX + IMG_W + 2);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    localparam logic [KW-1:0] K_WIN      = KW'(IMG_W + 1);
    localparam logic [KW-1:0] K_LAST_PIX = KW'(NPIX - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(NFEED - 1);
    localparam logic [XW-1:0] X_MAX      = XW'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t              state_q;
    logic [KW-1:0]       k_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XW-1:0]       cx_q;
    logic [YW-1:0]       cy_q;
    logic                busy_q, done_q, lb_rst_q, lb_in_valid_q, lb_zero_q, conv_valid_q;
    logic [XW-1:0]       out_x_q;
    logic [YW-1:0]       out_y_q;

    logic                windowed, feeding, issue;
    logic [KW-1:0]       k_d;
    logic [ADDR_W-1:0]   addr_d;

    // Feeds before the first full window never touch the MAC array, so they ignore conv_ready.
    assign windowed = (k_q >= K_WIN);
    assign feeding  = (state_q == STREAM) || (state_q == FLUSH);
    assign issue    = feeding && (!windowed || conv_ready);
    assign k_d      = k_q + KW'(1);
    assign addr_d   = addr_q + ADDR_W'(1);

    assign mem_rd_en   = issue && (state_q == STREAM);
    assign mem_addr    = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign lb_rst      = lb_rst_q;
    assign lb_in_valid = lb_in_valid_q;
    assign lb_zero     = lb_zero_q;
    assign conv_valid  = conv_valid_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            addr_q        <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lb_rst_q      <= 1'b0;
            lb_in_valid_q <= 1'b0;
            lb_zero_q     <= 1'b0;
            conv_valid_q  <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
        end else begin
            lb_rst_q      <= 1'b0;
            done_q        <= 1'b0;
            lb_in_valid_q <= issue;
            lb_zero_q     <= issue && (state_q == FLUSH);
            conv_valid_q  <= issue && windowed;

            if (issue && windowed) begin
                out_x_q <= cx_q;
                out_y_q <= cy_q;
                if (cx_q == X_MAX) begin
                    cx_q <= '0;
                    cy_q <= cy_q + YW'(1);
                end else begin
                    cx_q <= cx_q + XW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    // done_q high means this is the done cycle: a start here is dropped.
                    if (start && !done_q) begin
                        addr_q   <= cfg_base;
                        k_q      <= '0;
                        cx_q     <= '0;
                        cy_q     <= '0;
                        lb_rst_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        k_q    <= k_d;
                        addr_q <= addr_d;
                        if (k_q == K_LAST_PIX) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (issue) begin
                        k_q <= k_d;
                        if (k_q == K_LAST) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench for conv_stream_ctrl on a 4x4 image: driver queues expectations, negedge monitor checks.
module tb_conv_stream_ctrl;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, start, conv_ready;
    logic [AW-1:0] cfg_base;
    logic          busy, done, mem_rd_en, lb_rst, lb_in_valid, lb_zero, conv_valid;
    logic [AW-1:0] mem_addr;
    logic [1:0]    out_x, out_y;

    conv_stream_ctrl #(.IMG_H(H), .IMG_W(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .lb_rst(lb_rst), .lb_in_valid(lb_in_valid), .lb_zero(lb_zero),
        .conv_ready(conv_ready), .conv_valid(conv_valid), .out_x(out_x), .out_y(out_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [AW-1:0] addr_exp[$];
    logic [3:0]    xy_exp[$];
    bit            zero_exp[$];

    int cyc = 0, lb_cnt = 0, cv_cnt = 0, lbrst_cyc = 0, lbrst_cnt = 0, done_cnt = 0;
    bit prev_lb = 1'b0, rdy_prev = 1'b0, full_speed = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (lb_rst === 1'b1) begin
            lbrst_cnt++;
            lbrst_cyc = cyc;
            lb_cnt    = 0;
            cv_cnt    = 0;
        end
        if (mem_rd_en === 1'b1) begin
            check("addr expected", 32'(addr_exp.size() > 0), 1);
            if (addr_exp.size() > 0) check("mem_addr", 32'(mem_addr), 32'(addr_exp.pop_front()));
        end
        if (lb_in_valid === 1'b1) begin
            check("feed expected", 32'(zero_exp.size() > 0), 1);
            if (zero_exp.size() > 0) check("lb_zero", 32'(lb_zero), 32'(zero_exp.pop_front()));
            if (full_speed || lb_cnt < W + 1) check("feed cycle", cyc, lbrst_cyc + 1 + lb_cnt);
            lb_cnt++;
        end
        if (conv_valid === 1'b1) begin
            check("conv_ready in prior cycle", 32'(rdy_prev), 1);
            check("window expected", 32'(xy_exp.size() > 0), 1);
            if (xy_exp.size() > 0) check("out_y,out_x", 32'({out_y, out_x}), 32'(xy_exp.pop_front()));
            cv_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("feeds at done", lb_cnt, H * W + W + 1);
            check("windows at done", cv_cnt, H * W);
            check("done right after last feed", 32'(prev_lb), 1);
            check("busy low at done", 32'(busy), 0);
        end
        prev_lb  = (lb_in_valid === 1'b1);
        rdy_prev = (conv_ready === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_layer(input logic [AW-1:0] base);
        for (int i = 0; i < H * W; i++) addr_exp.push_back(base + AW'(i));
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) xy_exp.push_back({2'(y), 2'(x)});
        for (int i = 0; i < H * W + W + 1; i++) zero_exp.push_back(i >= H * W);
    endtask

    task automatic start_layer(input logic [AW-1:0] base);
        cfg_base = base;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Returns 3 ns into the cycle where done is high.
    task automatic run_to_done(input bit toggle, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (toggle && i > 0) conv_ready = ~conv_ready;
            #3;
            if (done === 1'b1) ok = 1'b1;
            else tick();
        end
        check("done within budget", 32'(ok), 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " addr queue empty"}, addr_exp.size(), 0);
        check({tag, " window queue empty"}, xy_exp.size(), 0);
        check({tag, " feed queue empty"}, zero_exp.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " mem_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 0);
        check({tag, " lb_rst"}, 32'(lb_rst), 0);
        check({tag, " lb_in_valid"}, 32'(lb_in_valid), 0);
        check({tag, " lb_zero"}, 32'(lb_zero), 0);
        check({tag, " conv_valid"}, 32'(conv_valid), 0);
        check({tag, " out_x/out_y"}, 32'({out_y, out_x}), 0);
    endtask

    int rst_mark, done_mark;

    initial begin
        rst = 1'b1; start = 1'b0; conv_ready = 1'b0; cfg_base = '0;
        repeat (3) tick();
        #2;
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Full-rate layer.
        full_speed = 1'b1; conv_ready = 1'b1;
        push_layer(12'h100);
        start_layer(12'h100);
        run_to_done(1'b0, 100);
        tick();
        full_speed = 1'b0;
        check("done count layer1", done_cnt, 1);
        check_drained("layer1");

        // conv_ready toggling every cycle.
        conv_ready = 1'b1;
        push_layer(12'h100);
        start_layer(12'h100);
        run_to_done(1'b1, 200);
        tick();
        check("done count toggle", done_cnt, 2);
        check_drained("toggle");

        // Ten-cycle stall at the first windowed feed.
        conv_ready = 1'b1;
        push_layer(12'h100);
        start_layer(12'h100);
        repeat (5) tick();
        conv_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            #3;
            check("stall mem_rd_en", 32'(mem_rd_en), 0);
            if (j > 0) begin
                check("stall lb_in_valid", 32'(lb_in_valid), 0);
                check("stall conv_valid", 32'(conv_valid), 0);
            end
            check("stall busy", 32'(busy), 1);
            tick();
        end
        conv_ready = 1'b1;
        #3;
        check("resume mem_rd_en", 32'(mem_rd_en), 1);
        check("resume mem_addr", 32'(mem_addr), 32'h105);
        tick();
        #3;
        check("resume conv_valid", 32'(conv_valid), 1);
        check("resume out xy", 32'({out_y, out_x}), 0);
        tick();
        run_to_done(1'b0, 100);
        tick();
        check_drained("stall");

        // Starts while busy and in the done cycle are dropped.
        push_layer(12'h100);
        start_layer(12'h100);
        rst_mark = lbrst_cnt + 1;
        repeat (8) tick();
        cfg_base = 12'h300; start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(1'b0, 100);
        cfg_base = 12'h500; start = 1'b1;
        tick();
        cfg_base = 12'h600;
        push_layer(12'h600);
        #3;
        check("lb_rst after done-cycle start", 32'(lb_rst), 0);
        check("lb_rst pulses so far", lbrst_cnt, rst_mark);
        tick();
        start = 1'b0;
        #3;
        check("lb_rst after accepted start", 32'(lb_rst), 1);
        tick();
        run_to_done(1'b0, 100);
        tick();
        check_drained("restart");

        // Abort with rst at feed 9.
        push_layer(12'h100);
        start_layer(12'h100);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr_exp.delete(); xy_exp.delete(); zero_exp.delete();
        #2;
        check_outputs_zero("abort");
        done_mark = done_cnt;
        repeat (6) tick();
        check("no done after abort", done_cnt, done_mark);
        push_layer(12'h200);
        start_layer(12'h200);
        run_to_done(1'b0, 100);
        tick();
        check_drained("after abort");

        // Address wrap at the top of SRAM.
        full_speed = 1'b1;
        push_layer(12'hFFC);
        start_layer(12'hFFC);
        run_to_done(1'b0, 100);
        tick();
        full_speed = 1'b0;
        check_drained("wrap");
        check("total done pulses", done_cnt, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_stream_ctrl.md
Name: conv_stream_ctrl

Overview:
- Per-layer sequencer for the 3x3 multi-channel line-buffer stage of the CNN accelerator.
- On start, it reads one N_CH activation vector per cycle from activation SRAM and drives the line buffer's in_valid.
- After the last pixel it appends zero "flush" pixels so the final rows produce windows.
- It emits one conv_valid per output pixel, tagged with its centre (x,y), under look-ahead backpressure from the MAC array.

Parameters:
- IMG_H, 28, feature-map height in pixels.
- IMG_W, 28, feature-map width in pixels.
- ADDR_W, 12, activation SRAM address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle layer start request
- cfg_base  in  ADDR_W  SRAM address of pixel (0,0); sampled when start is accepted
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the last window has been issued
- mem_rd_en  out  1  SRAM read strobe; data returns the next cycle
- mem_addr  out  ADDR_W  SRAM read address
- lb_rst  out  1  one-cycle clear to the line buffer, pulsed on start acceptance
- lb_in_valid  out  1  line-buffer feed strobe
- lb_zero  out  1  datapath muxes zeros onto line-buffer in_vec when high
- conv_ready  in  1  look-ahead ready: high in cycle t guarantees acceptance of conv_valid in cycle t+1
- conv_valid  out  1  window at line-buffer output is a real output pixel
- out_x  out  $clog2(IMG_W)  window centre column
- out_y  out  $clog2(IMG_H)  window centre row

Behaviour:
- Reset values
  - State IDLE; all outputs 0.
  - All counters 0.
  - Reset mid-layer aborts immediately: no done pulse, busy drops next cycle.
- States and transitions
  - IDLE: on start, latch cfg_base, pulse lb_rst, go to STREAM. start is ignored whenever busy=1.
  - STREAM: issues IMG_H*IMG_W SRAM reads at addresses cfg_base+0 .. cfg_base+IMG_H*IMG_W-1, then goes to FLUSH.
  - FLUSH: issues IMG_W+1 zero feeds with no SRAM read; lb_zero=1 on the corresponding lb_in_valid cycles.
  - DRAIN: waits until the final feed has left the pipe, pulses done, returns to IDLE.
- Feed index k
  - k counts 0 .. IMG_H*IMG_W+IMG_W.
  - Total feeds = IMG_H*IMG_W+IMG_W+1.
  - Feed k is "windowed" iff k >= IMG_W+1.
- Advance rule
  - A feed is issued in cycle t iff state is STREAM or FLUSH and (feed not windowed or conv_ready=1).
  - Otherwise the controller holds: k, address and state are unchanged.
- Pipeline, fixed latency 1
  - A feed issued in cycle t produces mem_rd_en (STREAM only) in t.
  - In t+1 it produces lb_in_valid=1, lb_zero per source, and conv_valid=1 if windowed.
  - No feeds are dropped or duplicated across stalls.
- Coordinates
  - The windowed feed k carries centre index c = k-(IMG_W+1).
  - out_x = c mod IMG_W, out_y = c div IMG_W, kept as wrap counters (no divider).
  - out_x wraps IMG_W-1 -> 0 and increments out_y.
  - Coordinates are registered alongside conv_valid.
  - Exactly IMG_H*IMG_W conv_valid pulses per layer, in raster order.
- done
  - Asserts in the cycle after the last lb_in_valid.
  - busy deasserts in the same cycle as done.
  - A start in that same cycle is ignored; a new start is accepted one cycle later.
- Widths
  - mem_addr = cfg_base + pixel index, wraps modulo 2^ADDR_W with no error flag.
  - The feed counter is $clog2(IMG_H*IMG_W+IMG_W+2) bits.
- Consumer obligations
  - conv_ready is ignored for non-windowed feeds.
  - The consumer must not rely on conv_ready being sampled in IDLE or DRAIN.

Test Plan:
- IMG_H=IMG_W=4, cfg_base=0x100, conv_ready=1 held high:
  - expect 16 mem_rd_en at 0x100..0x10F, then 5 lb_zero feeds;
  - 21 lb_in_valid cycles back-to-back;
  - 16 conv_valid with (x,y) from (0,0) to (3,3) in raster order;
  - done exactly 1 cycle after the 21st lb_in_valid.
- Same configuration, conv_ready toggling 1,0,1,0:
  - every windowed feed is issued only after conv_ready=1 in the prior cycle;
  - still 16 conv_valid, with no repeated or skipped (x,y) and no repeated or skipped address;
  - the first 5 feeds are not stalled.
- conv_ready=0 from k=5 for 10 cycles:
  - mem_rd_en, lb_in_valid and conv_valid stay 0 for the whole stall;
  - busy=1 throughout;
  - streaming resumes at address 0x105 with out (0,0) one cycle after conv_ready rises.
- start pulsed again mid-layer, and again in the done cycle:
  - both are ignored: no lb_rst, no cfg_base relatch, conv_valid count unchanged;
  - a start one cycle after done is accepted with an lb_rst pulse.
- rst asserted at k=9:
  - all outputs are 0 on the next cycle, state IDLE, no done pulse;
  - the following start runs a full, correct 21-feed layer.
- cfg_base=2^ADDR_W-4 with a 4x4 image:
  - addresses wrap to 0x000 after 0xFFF;
  - coordinates and counts are unaffected.
